// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FIFO with tkeep/tlast sideband and optional store-and-forward
// First-word fall-through storage; s_axis_tready is registered so m_axis_tready never reaches it combinationally.
module axis_fifo #(
   parameter int TDATA_BYTES = 1,
   parameter int DEPTH       = 16,
   parameter int PACKET_MODE = 0
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [TDATA_BYTES*8-1:0]   s_axis_tdata,
   input  logic [TDATA_BYTES-1:0]     s_axis_tkeep,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [TDATA_BYTES*8-1:0]   m_axis_tdata,
   output logic [TDATA_BYTES-1:0]     m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = TDATA_BYTES * 8;
   localparam int EW = DW + TDATA_BYTES + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_next;
   logic [CW-1:0]  pkt_cnt;
   logic           forced;
   logic           ready_q;
   logic           wr_en;
   logic           rd_en;
   logic           wr_tlast;
   logic           rd_tlast;
   logic           has_data;
   logic           release_ok;

   assign wr_en    = s_axis_tvalid && ready_q;
   assign rd_en    = m_axis_tvalid && m_axis_tready;
   assign wr_tlast = wr_en && s_axis_tlast;
   assign rd_tlast = rd_en && m_axis_tlast;

   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];

   // A full FIFO holding no complete packet must drain anyway or an oversize packet would deadlock.
   assign has_data      = (count != '0);
   assign release_ok    = (pkt_cnt != '0) || forced || (count == DEPTH_C);
   assign m_axis_tvalid = (PACKET_MODE != 0) ? (has_data && release_ok) : has_data;
   assign s_axis_tready = ready_q;
   assign fill_level    = count;

   always_comb begin
      count_next = count;
      if (wr_en && !rd_en)
         count_next = count + CW'(1);
      else if (rd_en && !wr_en)
         count_next = count - CW'(1);
   end

   always_ff @(posedge aclk) begin
      if (wr_en)
         mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         pkt_cnt <= '0;
         forced  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         count   <= count_next;
         ready_q <= (count_next < DEPTH_C);

         if (wr_tlast && !rd_tlast)
            pkt_cnt <= pkt_cnt + CW'(1);
         else if (rd_tlast && !wr_tlast)
            pkt_cnt <= pkt_cnt - CW'(1);

         // Override latches at full-without-packet and holds until that packet's tlast leaves.
         if (forced)
            forced <= !rd_tlast;
         else
            forced <= (count == DEPTH_C) && (pkt_cnt == '0);
      end
   end

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - scoreboard bench for axis_fifo (cut-through 4B/16 and store-and-forward 4B/8)
module tb_axis_fifo;

   logic        aclk;
   logic        aresetn;

   logic [31:0] ct_s_tdata;
   logic [3:0]  ct_s_tkeep;
   logic        ct_s_tlast, ct_s_tvalid, ct_s_tready;
   logic [31:0] ct_m_tdata;
   logic [3:0]  ct_m_tkeep;
   logic        ct_m_tlast, ct_m_tvalid, ct_m_tready;
   logic [4:0]  ct_fill;

   logic [31:0] sf_s_tdata;
   logic [3:0]  sf_s_tkeep;
   logic        sf_s_tlast, sf_s_tvalid, sf_s_tready;
   logic [31:0] sf_m_tdata;
   logic [3:0]  sf_m_tkeep;
   logic        sf_m_tlast, sf_m_tvalid, sf_m_tready;
   logic [3:0]  sf_fill;

   int n_tests = 0;
   int n_fail  = 0;

   logic [36:0] ct_q[$];
   logic [36:0] sf_q[$];

   axis_fifo #(.TDATA_BYTES(4), .DEPTH(16), .PACKET_MODE(0)) dut_ct (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(ct_s_tdata), .s_axis_tkeep(ct_s_tkeep), .s_axis_tlast(ct_s_tlast),
      .s_axis_tvalid(ct_s_tvalid), .s_axis_tready(ct_s_tready),
      .m_axis_tdata(ct_m_tdata), .m_axis_tkeep(ct_m_tkeep), .m_axis_tlast(ct_m_tlast),
      .m_axis_tvalid(ct_m_tvalid), .m_axis_tready(ct_m_tready),
      .fill_level(ct_fill)
   );

   axis_fifo #(.TDATA_BYTES(4), .DEPTH(8), .PACKET_MODE(1)) dut_sf (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(sf_s_tdata), .s_axis_tkeep(sf_s_tkeep), .s_axis_tlast(sf_s_tlast),
      .s_axis_tvalid(sf_s_tvalid), .s_axis_tready(sf_s_tready),
      .m_axis_tdata(sf_m_tdata), .m_axis_tkeep(sf_m_tkeep), .m_axis_tlast(sf_m_tlast),
      .m_axis_tvalid(sf_m_tvalid), .m_axis_tready(sf_m_tready),
      .fill_level(sf_fill)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drives one beat from posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input bit sf, input logic [31:0] d, input logic [3:0] k, input logic l);
      int  t    = 0;
      bit  done = 0;
      if (sf) begin
         sf_s_tdata = d; sf_s_tkeep = k; sf_s_tlast = l; sf_s_tvalid = 1'b1;
      end else begin
         ct_s_tdata = d; ct_s_tkeep = k; ct_s_tlast = l; ct_s_tvalid = 1'b1;
      end
      while (!done) begin
         @(negedge aclk);
         if (sf ? sf_s_tready : ct_s_tready) begin
            if (sf) sf_q.push_back({l, k, d});
            else    ct_q.push_back({l, k, d});
            done = 1;
         end else if (++t > 200) begin
            check(sf ? "sf_send_timeout" : "ct_send_timeout", 1, 0);
            done = 1;
         end
         @(posedge aclk); #1;
      end
      if (sf) sf_s_tvalid = 1'b0;
      else    ct_s_tvalid = 1'b0;
   endtask

   task automatic drain(input bit sf);
      int t = 0;
      while ((sf ? (sf_q.size() != 0 || sf_fill != 0) : (ct_q.size() != 0 || ct_fill != 0)) && t < 100) begin
         @(posedge aclk); #1;
         t++;
      end
      check(sf ? "sf_drain_queue" : "ct_drain_queue", sf ? sf_q.size() : ct_q.size(), 0);
      check(sf ? "sf_drain_fill" : "ct_drain_fill", sf ? sf_fill : ct_fill, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ct_tready"}, ct_s_tready, 0);
      check({tag, "_ct_tvalid"}, ct_m_tvalid, 0);
      check({tag, "_ct_fill"}, ct_fill, 0);
      check({tag, "_sf_tready"}, sf_s_tready, 0);
      check({tag, "_sf_tvalid"}, sf_m_tvalid, 0);
      check({tag, "_sf_fill"}, sf_fill, 0);
   endtask

   task automatic do_reset(input int cycles);
      aresetn = 1'b0;
      ct_s_tvalid = 1'b0;
      sf_s_tvalid = 1'b0;
      #1;
      ct_q.delete();
      sf_q.delete();
      check_idle("rst_async");
      repeat (cycles) begin
         @(negedge aclk);
         check_idle("rst_hold");
      end
      @(negedge aclk); #2;
      aresetn = 1'b1;
      #1;
      check("rst_release_tready_low", ct_s_tready, 0);
      @(posedge aclk); #1;
      check("rst_ct_tready_up", ct_s_tready, 1);
      check("rst_sf_tready_up", sf_s_tready, 1);
      check("rst_ct_fill", ct_fill, 0);
      check("rst_sf_fill", sf_fill, 0);
   endtask

   logic [36:0] ct_prev, sf_prev;
   bit          ct_hold, sf_hold;

   always @(negedge aclk) begin
      if (!aresetn) begin
         ct_hold = 0;
         sf_hold = 0;
      end else begin
         if (ct_hold) begin
            check("ct_hold_valid", ct_m_tvalid, 1);
            check("ct_hold_data", {ct_m_tlast, ct_m_tkeep, ct_m_tdata}, ct_prev);
         end
         if (ct_m_tvalid && ct_m_tready) begin
            if (ct_q.size() == 0) check("ct_unexpected_beat", 1, 0);
            else check("ct_out", {ct_m_tlast, ct_m_tkeep, ct_m_tdata}, ct_q.pop_front());
         end
         ct_hold = ct_m_tvalid && !ct_m_tready;
         ct_prev = {ct_m_tlast, ct_m_tkeep, ct_m_tdata};

         if (sf_hold) begin
            check("sf_hold_valid", sf_m_tvalid, 1);
            check("sf_hold_data", {sf_m_tlast, sf_m_tkeep, sf_m_tdata}, sf_prev);
         end
         if (sf_m_tvalid && sf_m_tready) begin
            if (sf_q.size() == 0) check("sf_unexpected_beat", 1, 0);
            else check("sf_out", {sf_m_tlast, sf_m_tkeep, sf_m_tdata}, sf_q.pop_front());
         end
         sf_hold = sf_m_tvalid && !sf_m_tready;
         sf_prev = {sf_m_tlast, sf_m_tkeep, sf_m_tdata};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      aresetn = 1'b0;
      ct_s_tdata = '0; ct_s_tkeep = '0; ct_s_tlast = 1'b0; ct_s_tvalid = 1'b0; ct_m_tready = 1'b0;
      sf_s_tdata = '0; sf_s_tkeep = '0; sf_s_tlast = 1'b0; sf_s_tvalid = 1'b0; sf_m_tready = 1'b0;
      @(posedge aclk); #1;
      do_reset(5);

      // cut-through streaming
      ct_m_tready = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         send(0, 32'(i), 4'(i), (i % 8) == 0);
         check("ct_stream_tvalid", ct_m_tvalid, 1);
         check("ct_stream_fill_le1", ct_fill <= 5'd1, 1);
      end
      drain(0);

      // fill to 16 and release one slot
      ct_m_tready = 1'b0;
      for (int i = 1; i <= 16; i++) send(0, 32'h100 + 32'(i), 4'hF, 1'b0);
      check("ct_full_tready", ct_s_tready, 0);
      check("ct_full_fill", ct_fill, 16);
      fork
         begin
            for (int i = 17; i <= 20; i++) send(0, 32'h100 + 32'(i), 4'hF, i == 20);
         end
         begin
            repeat (3) begin @(posedge aclk); #1; end
            check("ct_stall_tready", ct_s_tready, 0);
            check("ct_stall_fill", ct_fill, 16);
            ct_m_tready = 1'b1;
            @(posedge aclk); #1;
            ct_m_tready = 1'b0;
            check("ct_bubble_tready", ct_s_tready, 1);
            check("ct_bubble_fill", ct_fill, 15);
            @(posedge aclk); #1;
            check("ct_refill_fill", ct_fill, 16);
            check("ct_refill_tready", ct_s_tready, 0);
            ct_m_tready = 1'b1;
         end
      join
      drain(0);

      // store-and-forward 5-beat packet
      sf_m_tready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         send(1, 32'h10 + 32'(i), 4'(i), 1'b0);
         check("sf_gate_tvalid", sf_m_tvalid, 0);
      end
      send(1, 32'h15, 4'hA, 1'b1);
      check("sf_release_tvalid", sf_m_tvalid, 1);
      drain(1);

      // tlast read and tlast write on the same edge
      sf_m_tready = 1'b0;
      send(1, 32'hA1, 4'hF, 1'b0);
      send(1, 32'hA2, 4'hF, 1'b1);
      send(1, 32'hB1, 4'h3, 1'b0);
      sf_m_tready = 1'b1;
      @(posedge aclk); #1;
      send(1, 32'hB2, 4'hC, 1'b1);
      sf_m_tready = 1'b0;
      check("sf_simul_tvalid", sf_m_tvalid, 1);
      check("sf_simul_fill", sf_fill, 2);
      sf_m_tready = 1'b1;
      drain(1);
      check("sf_simul_idle_tvalid", sf_m_tvalid, 0);

      // oversize 12-beat packet into depth 8
      sf_m_tready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 12; i++) send(1, 32'h200 + 32'(i), 4'hF, i == 12);
         end
         begin
            int t = 0;
            while (sf_fill != 4'd8 && t < 200) begin @(posedge aclk); #1; t++; end
            check("sf_over_fill", sf_fill, 8);
            check("sf_over_tvalid", sf_m_tvalid, 1);
            check("sf_over_tready", sf_s_tready, 0);
            sf_m_tready = 1'b1;
         end
      join
      drain(1);
      check("sf_over_idle_tvalid", sf_m_tvalid, 0);
      send(1, 32'h301, 4'hF, 1'b0);
      check("sf_resume_gate", sf_m_tvalid, 0);
      send(1, 32'h302, 4'hF, 1'b1);
      check("sf_resume_release", sf_m_tvalid, 1);
      drain(1);

      // reset mid-packet
      sf_m_tready = 1'b0;
      for (int i = 1; i <= 3; i++) send(1, 32'h400 + 32'(i), 4'hF, 1'b0);
      check("sf_mid_fill", sf_fill, 3);
      check("sf_mid_tvalid", sf_m_tvalid, 0);
      do_reset(3);
      check("sf_post_rst_tvalid", sf_m_tvalid, 0);
      sf_m_tready = 1'b1;
      send(1, 32'h501, 4'h1, 1'b0);
      send(1, 32'h502, 4'h2, 1'b1);
      drain(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
